dmem_responder: RTL

- Multi-cycle data-memory responder. Serves load/store requests issued by the CPU's memory stage over a req/ready/ack handshake.
- Models a memory with configurable access latency so the pipeline stall path can be exercised.
- Word-organised internal storage; flags misaligned or out-of-range accesses instead of performing them.

---
 rtl/dmem_responder_pkg.sv | 39 +++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder_pkg
//  Description : Shared constants, types and helpers for the data-memory
//                responder and the CPU memory stage that talks to it.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    // Datapath geometry
    localparam int c_WORD_W   = 32;
    localparam int c_OFFSET_W = 2;
    localparam int c_CNT_W    = 4;   // holds LATENCY-1 for LATENCY up to 15

    // State encoding
    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_BUSY = 2'b01;
    localparam logic [1:0] c_RESP = 2'b10;

    // Access type carried on we_i
    localparam logic c_LOAD  = 1'b0;
    localparam logic c_STORE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = c_IDLE,
        ST_BUSY = c_BUSY,
        ST_RESP = c_RESP
    } state_t;

    // An access is performed only if word-aligned and inside the storage.
    function automatic logic addr_ok(input logic [c_WORD_W-1:0] addr,
                                     input int                  depth);
        logic [c_WORD_W-1:0] w_word_idx;
        w_word_idx = {{c_OFFSET_W{1'b0}}, addr[c_WORD_W-1:c_OFFSET_W]};
        return (addr[c_OFFSET_W-1:0] == '0) && (w_word_idx < $unsigned(depth));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : DEPTH x 32 word storage, synchronous write, combinational
//                read on a single shared address.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [c_WORD_W-1:0] wdata_i,
    output logic [c_WORD_W-1:0] rdata_o
);

    logic [c_WORD_W-1:0] r_mem_q [DEPTH];

    // Write port: contents are deliberately not touched by reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Multi-cycle load/store responder with configurable latency,
//                req/ready/ack handshake and misaligned / out-of-range error
//                reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [c_WORD_W-1:0] addr_i,
    input  logic [c_WORD_W-1:0] wdata_i,
    output logic                ready_o,
    output logic                ack_o,
    output logic [c_WORD_W-1:0] rdata_o,
    output logic                err_o
);

    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);

    state_t              r_state_q,  w_state_d;
    logic [c_CNT_W-1:0]  r_cnt_q,    w_cnt_d;
    logic                r_we_q,     w_we_d;
    logic [c_WORD_W-1:0] r_addr_q,   w_addr_d;
    logic [c_WORD_W-1:0] r_wdata_q,  w_wdata_d;
    logic                r_ack_q,    w_ack_d;
    logic                r_err_q,    w_err_d;
    logic [c_WORD_W-1:0] r_rdata_q,  w_rdata_d;

    logic                w_accept;
    logic                w_valid;
    logic                w_mem_we;
    logic [c_WORD_W-1:0] w_mem_rdata;

    // Ready whenever not busy; reset forces it low so nothing is accepted.
    assign ready_o  = !rst_i && (r_state_q != ST_BUSY);
    assign w_accept = req_i && ready_o;
    assign w_valid  = addr_ok(r_addr_q, DEPTH);

    // Next-state, request capture, commit and response generation.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_we_d    = r_we_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_ack_d   = 1'b0;
        w_err_d   = 1'b0;
        w_rdata_d = '0;
        w_mem_we  = 1'b0;

        unique case (r_state_q)
            ST_BUSY: begin
                if (r_cnt_q != '0) begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end else begin
                    // Commit edge: the store lands here, so a load accepted
                    // in the following RESP cycle already sees it.
                    w_state_d = ST_RESP;
                    w_ack_d   = 1'b1;
                    w_err_d   = !w_valid;
                    if (w_valid && (r_we_q == c_STORE)) begin
                        w_mem_we = !rst_i;
                    end else if (w_valid) begin
                        w_rdata_d = w_mem_rdata;
                    end
                end
            end
            ST_IDLE, ST_RESP: begin
                w_state_d = ST_IDLE;
                if (w_accept) begin
                    w_state_d = ST_BUSY;
                    w_cnt_d   = c_CNT_LOAD;
                    w_we_d    = we_i;
                    w_addr_d  = addr_i;
                    w_wdata_d = wdata_i;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= '0;
            r_ack_q   <= 1'b0;
            r_err_q   <= 1'b0;
            r_rdata_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_ack_q   <= w_ack_d;
            r_err_q   <= w_err_d;
            r_rdata_q <= w_rdata_d;
        end
        r_we_q    <= w_we_d;
        r_addr_q  <= w_addr_d;
        r_wdata_q <= w_wdata_d;
    end

    assign ack_o   = r_ack_q;
    assign err_o   = r_err_q;
    assign rdata_o = r_rdata_q;

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (c_ADDR_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (w_mem_we),
        .addr_i  (r_addr_q[c_ADDR_W+c_OFFSET_W-1:c_OFFSET_W]),
        .wdata_i (r_wdata_q),
        .rdata_o (w_mem_rdata)
    );

endmodule
`default_nettype wire
